bp_run_sequencer: RTL and testbench

Run-control sequencer for the BP engine's six-stage instruction datapath (mem1..mem6, 16 instruction slots each). On `io_beginRun` it latches the tag and round budget, waits until the 64-entry input buffer is fully valid, then sweeps instruction addresses 0..`NUM_INSTR`-1 through a six-stage enable/address pipeline once per round. It sits between the host-side load interface and the memory read ports, and reports busy/done/round status back to the host.

---
 rtl/bp_pkg.sv | 21 ++
 rtl/bp_stage_pipe.sv | 26 ++
 rtl/bp_run_sequencer.sv | 118 +++++++++++
 tb/tb_bp_run_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared sizing constants and FSM state encoding for the BP run sequencer.
package bp_pkg;

  localparam int NUM_INSTR   = 16;
  localparam int NUM_STAGES  = 6;
  localparam int INBUF_DEPTH = 64;
  localparam int AW          = $clog2(NUM_INSTR);

  localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DATA = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_ROUND_END = 3'd4,
    ST_DONE      = 3'd5
  } bp_seq_state_t;

endpackage

// File: rtl/bp_stage_pipe.sv
// NUM_STAGES-deep enable/address shift register feeding the memory read ports.
// Stage 0 sits in the low bits; hold freezes every stage.
module bp_stage_pipe
  import bp_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     hold,
  input  logic                     in_en,
  input  logic [AW-1:0]            in_addr,
  output logic [NUM_STAGES-1:0]    en,
  output logic [NUM_STAGES*AW-1:0] addr
);

  // Shift one stage per non-held cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      en   <= {NUM_STAGES{1'b0}};
      addr <= {(NUM_STAGES*AW){1'b0}};
    end else if (!hold) begin
      en   <= {en[NUM_STAGES-2:0], in_en};
      addr <= {addr[(NUM_STAGES-1)*AW-1:0], in_addr};
    end
  end

endmodule

// File: rtl/bp_run_sequencer.sv
// Run-control sequencer: waits for a full input buffer, then sweeps all
// instruction addresses through the stage pipeline once per round.
module bp_run_sequencer
  import bp_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_beginRun,
  input  logic [2:0]               io_cfg_rounds,
  input  logic [1:0]               io_tag_in,
  input  logic [INBUF_DEPTH-1:0]   io_inBuf_valid,
  input  logic                     io_stall,
  output logic [NUM_STAGES-1:0]    io_stage_en,
  output logic [NUM_STAGES*AW-1:0] io_stage_addr,
  output logic [2:0]               io_roundCnt,
  output logic [1:0]               io_tag_out,
  output logic                     io_busy,
  output logic                     io_done,
  output logic                     io_inBuf_clear
);

  bp_seq_state_t   state;
  logic [AW-1:0]   instr_ptr;
  logic [2:0]      rounds;
  logic            data_ready;
  logic            inj_en;

  assign data_ready = &io_inBuf_valid;

  // Injection is decided on the edge that enters each ISSUE cycle, so address a
  // is on stage 0 during ISSUE cycle a; instr_ptr runs one ahead and wraps to 0
  // in the cycle showing the last address.
  always_comb begin
    inj_en = 1'b0;
    case (state)
      ST_WAIT_DATA: inj_en = data_ready;
      ST_ISSUE:     inj_en = (instr_ptr != ADDR_ZERO);
      ST_ROUND_END: inj_en = (io_roundCnt != rounds);
      default:      inj_en = 1'b0;
    endcase
  end

  bp_stage_pipe u_pipe (
    .clock   (clock),
    .reset   (reset),
    .hold    (io_stall),
    .in_en   (inj_en),
    .in_addr (instr_ptr),
    .en      (io_stage_en),
    .addr    (io_stage_addr)
  );

  // Sequencer FSM with its latches and status outputs; a stall freezes all of it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      instr_ptr      <= ADDR_ZERO;
      rounds         <= 3'd0;
      io_roundCnt    <= 3'd0;
      io_tag_out     <= 2'd0;
      io_busy        <= 1'b0;
      io_done        <= 1'b0;
      io_inBuf_clear <= 1'b0;
    end else if (!io_stall) begin
      io_done        <= 1'b0;
      io_inBuf_clear <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (io_beginRun) begin
            rounds      <= io_cfg_rounds;
            io_tag_out  <= io_tag_in;
            io_roundCnt <= 3'd0;
            io_busy     <= 1'b1;
            state       <= ST_WAIT_DATA;
          end
        end
        ST_WAIT_DATA: begin
          if (data_ready) begin
            instr_ptr <= instr_ptr + ADDR_ONE;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (instr_ptr == ADDR_ZERO) begin
            state <= ST_DRAIN;
          end else begin
            instr_ptr <= instr_ptr + ADDR_ONE;
          end
        end
        ST_DRAIN: begin
          if (io_stage_en == {NUM_STAGES{1'b0}}) begin
            state <= ST_ROUND_END;
          end
        end
        ST_ROUND_END: begin
          if (io_roundCnt == rounds) begin
            io_done        <= 1'b1;
            io_inBuf_clear <= 1'b1;
            state          <= ST_DONE;
          end else begin
            io_roundCnt <= io_roundCnt + 3'd1;
            instr_ptr   <= instr_ptr + ADDR_ONE;
            state       <= ST_ISSUE;
          end
        end
        ST_DONE: begin
          io_busy <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          io_busy <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bp_run_sequencer.sv
// Randomised bench for bp_run_sequencer against a cycle-count model of a run:
// outputs are derived from the number of non-stalled cycles since buffer-ready.
module tb_bp_run_sequencer;
  import bp_pkg::*;

  localparam int ROUND_LEN = 23;

  logic                     clock = 1'b0;
  logic                     reset;
  logic                     io_beginRun;
  logic [2:0]               io_cfg_rounds;
  logic [1:0]               io_tag_in;
  logic [INBUF_DEPTH-1:0]   io_inBuf_valid;
  logic                     io_stall;
  logic [NUM_STAGES-1:0]    io_stage_en;
  logic [NUM_STAGES*AW-1:0] io_stage_addr;
  logic [2:0]               io_roundCnt;
  logic [1:0]               io_tag_out;
  logic                     io_busy;
  logic                     io_done;
  logic                     io_inBuf_clear;

  bp_run_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .io_beginRun    (io_beginRun),
    .io_cfg_rounds  (io_cfg_rounds),
    .io_tag_in      (io_tag_in),
    .io_inBuf_valid (io_inBuf_valid),
    .io_stall       (io_stall),
    .io_stage_en    (io_stage_en),
    .io_stage_addr  (io_stage_addr),
    .io_roundCnt    (io_roundCnt),
    .io_tag_out     (io_tag_out),
    .io_busy        (io_busy),
    .io_done        (io_done),
    .io_inBuf_clear (io_inBuf_clear)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: phase 0 idle, 1 waiting for data, 2 running (m_e = effective cycle).
  int         m_phase = 0;
  int         m_e = 0;
  int         m_R = 1;
  int         m_last_round = 0;
  logic [1:0] m_tag = 2'd0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [NUM_STAGES-1:0]    e_en;
    logic [NUM_STAGES*AW-1:0] e_addr;
    logic [2:0]               e_round;
    logic                     e_busy;
    logic                     e_done;
    int                       p;
    e_en    = '0;
    e_addr  = '0;
    e_done  = 1'b0;
    e_busy  = (m_phase != 0);
    e_round = 3'(m_last_round);
    if (m_phase == 1) e_round = 3'd0;
    if (m_phase == 2) begin
      if (m_e < ROUND_LEN * m_R) begin
        e_round = 3'(m_e / ROUND_LEN);
        p = m_e % ROUND_LEN;
        for (int k = 0; k < NUM_STAGES; k++) begin
          if (p - k >= 0 && p - k < NUM_INSTR) begin
            e_en[k] = 1'b1;
            e_addr[k*AW +: AW] = AW'(p - k);
          end
        end
      end else begin
        e_round = 3'(m_R - 1);
        e_done  = 1'b1;
      end
    end
    check_val("stage_en",   64'(io_stage_en),    64'(e_en));
    check_val("stage_addr", 64'(io_stage_addr),  64'(e_addr));
    check_val("round",      64'(io_roundCnt),    64'(e_round));
    check_val("tag",        64'(io_tag_out),     64'(m_tag));
    check_val("busy",       64'(io_busy),        64'(e_busy));
    check_val("done",       64'(io_done),        64'(e_done));
    check_val("clear",      64'(io_inBuf_clear), 64'(e_done));
  endtask

  task automatic step_model(input bit beg, input logic [2:0] cfg, input logic [1:0] tag,
                            input bit ready, input bit stall);
    if (!stall) begin
      case (m_phase)
        0: if (beg) begin
             m_phase = 1; m_tag = tag; m_R = int'(cfg) + 1; m_last_round = 0;
           end
        1: if (ready) begin
             m_phase = 2; m_e = 0;
           end
        default: if (m_e == ROUND_LEN * m_R) begin
             m_phase = 0; m_last_round = m_R - 1;
           end else begin
             m_e++;
           end
      endcase
    end
  endtask

  task automatic run_seq(input logic [2:0] cfg, input logic [1:0] tag, input int gate,
                         input int stall_e, input int stall_len, input bit rnd_stall,
                         input int reset_e, input bit mid_begin);
    int wait_cnt = 0;
    int left = stall_len;
    int issue_cyc = -1;
    int stalls = 0;
    bit done_seen = 1'b0;
    bit finished = 1'b0;
    bit beg, ready, stall;
    for (int c = 0; c < 1500 && !finished; c++) begin
      @(negedge clock);
      check_outputs();
      if (c > 0 && m_phase == 0) begin
        finished = 1'b1;
      end else begin
        if (m_phase == 2 && m_e == 0 && issue_cyc < 0) issue_cyc = c;
        if (io_done === 1'b1 && !done_seen && issue_cyc >= 0) begin
          done_seen = 1'b1;
          check_val("done_latency", 64'(c - issue_cyc), 64'(ROUND_LEN * m_R + stalls));
        end
        if (m_phase == 2 && m_e == reset_e) begin
          io_beginRun = 1'b0;
          io_stall = 1'b0;
          #2 reset = 1'b1;
          #1;
          m_phase = 0; m_tag = 2'd0; m_last_round = 0;
          check_outputs();
          @(negedge clock);
          reset = 1'b0;
          finished = 1'b1;
        end else begin
          beg = (c == 0) || (mid_begin && m_phase == 2 && m_e == 10);
          io_beginRun   = beg;
          io_cfg_rounds = (c == 0) ? cfg : 3'($urandom);
          io_tag_in     = (c == 0) ? tag : 2'($urandom);
          if (m_phase == 1 && wait_cnt < gate) begin
            io_inBuf_valid = ~(64'd1 << 37);
            wait_cnt++;
          end else if (m_phase == 2) begin
            io_inBuf_valid = {$urandom, $urandom};
          end else begin
            io_inBuf_valid = {INBUF_DEPTH{1'b1}};
          end
          ready = &io_inBuf_valid;
          if (rnd_stall) begin
            stall = (m_phase != 0) && ($urandom_range(0, 7) == 0);
          end else begin
            stall = (m_phase == 2 && m_e == stall_e && left > 0);
            if (stall) left--;
          end
          io_stall = stall;
          if (stall && m_phase == 2 && m_e < ROUND_LEN * m_R) stalls++;
          step_model(beg, io_cfg_rounds, io_tag_in, ready, stall);
        end
      end
    end
    if (!finished) check_val("run_timeout", 64'd0, 64'd1);
    io_beginRun = 1'b0;
    io_stall = 1'b0;
    io_inBuf_valid = {INBUF_DEPTH{1'b1}};
  endtask

  initial begin
    reset = 1'b1;
    io_beginRun = 1'b0;
    io_cfg_rounds = 3'd0;
    io_tag_in = 2'd0;
    io_inBuf_valid = {INBUF_DEPTH{1'b1}};
    io_stall = 1'b0;
    repeat (2) @(negedge clock);
    check_outputs();
    reset = 1'b0;

    run_seq(3'd0, 2'b01, 0,  -1, 0, 1'b0, -1,            1'b0); // basic
    run_seq(3'd2, 2'b10, 0,  -1, 0, 1'b0, -1,            1'b0); // multi-round
    run_seq(3'd0, 2'b11, 10, -1, 0, 1'b0, -1,            1'b0); // data gating
    run_seq(3'd0, 2'b01, 0,   7, 3, 1'b0, -1,            1'b0); // stall on addr 7
    run_seq(3'd1, 2'b10, 0,  -1, 0, 1'b0, -1,            1'b1); // ignored start
    run_seq(3'd1, 2'b11, 0,  -1, 0, 1'b0, ROUND_LEN + 5, 1'b0); // reset in round 1
    run_seq(3'd0, 2'b01, 0,  -1, 0, 1'b0, -1,            1'b0); // fresh run
    for (int i = 0; i < 12; i++) begin
      logic [2:0] rc;
      int rst_e;
      rc = 3'($urandom);
      rst_e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, ROUND_LEN * (int'(rc) + 1))) : -1;
      run_seq(rc, 2'($urandom), int'($urandom_range(0, 5)), -1, 0, 1'b1, rst_e, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
